// File: rtl/matrix_ctrl_pkg.sv
// Shared state encoding, error codes and default sizes for the matrix
// instruction sequencer and its watchdog.
package matrix_ctrl_pkg;

   localparam int PTR_W_DEFAULT       = 3;
   localparam int DATA_W_DEFAULT      = 256;
   localparam int MEM_DEPTH_DEFAULT   = 6;
   localparam int EXE_TIMEOUT_DEFAULT = 64;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_EXEC    = 3'd3,
      ST_WRITE   = 3'd4
   } seq_state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_BAD_PTR = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic ptr_out_of_range(input int unsigned ptr, input int unsigned depth);
      return ptr >= depth;
   endfunction

endpackage

// File: rtl/exe_watchdog.sv
// Cycle counter that bounds how long the sequencer waits for the engine.
// Counts while enabled; expired is high on the last allowed cycle.
module exe_watchdog #(
   parameter int EXE_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (EXE_TIMEOUT > 1) ? $clog2(EXE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(EXE_TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Saturates at LAST so a stuck enable can never wrap back to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix instruction through data_mem and the execution engine:
// read both operands, run the engine, optionally write back. Define
// BOUNDS_CHECK_EN to reject out-of-range pointers at accept time.
module matrix_op_sequencer
   import matrix_ctrl_pkg::*;
#(
   parameter int PTR_W       = PTR_W_DEFAULT,
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT,
   parameter int EXE_TIMEOUT = EXE_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [PTR_W-1:0]  instr_src1,
   input  logic [PTR_W-1:0]  instr_src2,
   input  logic [PTR_W-1:0]  instr_dst,
   input  logic              instr_wb,
   output logic [PTR_W-1:0]  mem_pointer1,
   output logic [PTR_W-1:0]  mem_pointer2,
   output logic              mem_read_data,
   input  logic [DATA_W-1:0] mem_data1,
   input  logic [DATA_W-1:0] mem_data2,
   output logic              mem_write_data,
   output logic [PTR_W-1:0]  mem_write_data_pointer,
   output logic [DATA_W-1:0] mem_data_to_write,
   output logic              exe_start,
   output logic [3:0]        exe_op,
   output logic [DATA_W-1:0] exe_opa,
   output logic [DATA_W-1:0] exe_opb,
   input  logic              exe_done,
   input  logic [DATA_W-1:0] exe_result,
   output logic              busy,
   output logic              retire,
   output logic [1:0]        err_code,
   output logic [15:0]       retired_count,
   output logic [2:0]        state_dbg
);

`ifdef BOUNDS_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // Instruction handshake: a transfer happens on a rising edge where both
   // instr_valid and instr_ready are high; instr_ready is high only in IDLE
   // and the offered fields need only be stable in that cycle.
   seq_state_t       state;
   logic [PTR_W-1:0] dst_q;
   logic             wb_q;
   logic             accept;
   logic             bad_ptr;
   logic             wd_expired;
   logic             fin;
   logic [1:0]       fin_code;

   assign accept    = instr_valid && instr_ready;
   assign state_dbg = state;

   assign bad_ptr = CHECK_EN &&
                    (ptr_out_of_range(32'(instr_src1), MEM_DEPTH) ||
                     ptr_out_of_range(32'(instr_src2), MEM_DEPTH) ||
                     (instr_wb && ptr_out_of_range(32'(instr_dst), MEM_DEPTH)));

   exe_watchdog #(
      .EXE_TIMEOUT (EXE_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != ST_EXEC),
      .enable  (state == ST_EXEC),
      .expired (wd_expired)
   );

   // Retire decision for this cycle; done takes priority over the watchdog.
   always_comb begin
      fin      = 1'b0;
      fin_code = ERR_OK;
      case (state)
         ST_IDLE: begin
            if (accept && bad_ptr) begin
               fin      = 1'b1;
               fin_code = ERR_BAD_PTR;
            end
         end
         ST_EXEC: begin
            if (exe_done) begin
               fin = !wb_q;
            end else if (wd_expired) begin
               fin      = 1'b1;
               fin_code = ERR_TIMEOUT;
            end
         end
         ST_WRITE: fin = 1'b1;
         default:  fin = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                  <= ST_IDLE;
         instr_ready            <= 1'b1;
         busy                   <= 1'b0;
         dst_q                  <= '0;
         wb_q                   <= 1'b0;
         mem_pointer1           <= '0;
         mem_pointer2           <= '0;
         mem_read_data          <= 1'b0;
         mem_write_data         <= 1'b0;
         mem_write_data_pointer <= '0;
         mem_data_to_write      <= '0;
         exe_start              <= 1'b0;
         exe_op                 <= '0;
         exe_opa                <= '0;
         exe_opb                <= '0;
         retire                 <= 1'b0;
         err_code               <= ERR_OK;
         retired_count          <= '0;
      end else begin
         exe_start      <= 1'b0;
         mem_read_data  <= 1'b0;
         mem_write_data <= 1'b0;
         retire         <= fin;
         err_code       <= fin_code;
         if (fin) begin
            retired_count <= retired_count + 16'd1;
         end
         case (state)
            ST_IDLE: begin
               if (accept && !bad_ptr) begin
                  state         <= ST_READ;
                  instr_ready   <= 1'b0;
                  busy          <= 1'b1;
                  mem_pointer1  <= instr_src1;
                  mem_pointer2  <= instr_src2;
                  mem_read_data <= 1'b1;
                  exe_op        <= instr_op;
                  dst_q         <= instr_dst;
                  wb_q          <= instr_wb;
               end
            end
            ST_READ: state <= ST_CAPTURE;
            ST_CAPTURE: begin
               exe_opa   <= mem_data1;
               exe_opb   <= mem_data2;
               exe_start <= 1'b1;
               state     <= ST_EXEC;
            end
            ST_EXEC: begin
               if (exe_done) begin
                  mem_data_to_write <= exe_result;
                  if (wb_q) begin
                     state                  <= ST_WRITE;
                     mem_write_data         <= 1'b1;
                     mem_write_data_pointer <= dst_q;
                  end else begin
                     state       <= ST_IDLE;
                     instr_ready <= 1'b1;
                     busy        <= 1'b0;
                  end
               end else if (wd_expired) begin
                  state       <= ST_IDLE;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            ST_WRITE: begin
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a data_mem model, a latency-
// programmable engine model and a write-data scoreboard.
module tb_matrix_op_sequencer;
   import matrix_ctrl_pkg::*;

   localparam int DW = 256;
   localparam logic [DW-1:0] M0   = {16{16'h1111}};
   localparam logic [DW-1:0] M1   = {16{16'h0202}};
   localparam logic [DW-1:0] M7   = {16{16'h0707}};
   localparam logic [DW-1:0] R_A  = {16{16'h1313}};
   localparam logic [DW-1:0] R_B  = {16{16'h2424}};
   localparam logic [DW-1:0] JUNK = {16{16'hDEAD}};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [3:0]    instr_op = '0;
   logic [2:0]    instr_src1 = '0, instr_src2 = '0, instr_dst = '0;
   logic          instr_wb = 1'b0;
   logic [2:0]    mem_pointer1, mem_pointer2, mem_write_data_pointer;
   logic          mem_read_data, mem_write_data;
   logic [DW-1:0] mem_data1, mem_data2, mem_data_to_write;
   logic          exe_start;
   logic [3:0]    exe_op;
   logic [DW-1:0] exe_opa, exe_opb;
   logic          exe_done = 1'b0;
   logic [DW-1:0] exe_result = '0;
   logic          busy, retire;
   logic [1:0]    err_code;
   logic [15:0]   retired_count;
   logic [2:0]    state_dbg;

   matrix_op_sequencer dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dst(instr_dst), .instr_wb(instr_wb),
      .mem_pointer1(mem_pointer1), .mem_pointer2(mem_pointer2), .mem_read_data(mem_read_data),
      .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_write_data(mem_write_data),
      .mem_write_data_pointer(mem_write_data_pointer), .mem_data_to_write(mem_data_to_write),
      .exe_start(exe_start), .exe_op(exe_op), .exe_opa(exe_opa), .exe_opb(exe_opb),
      .exe_done(exe_done), .exe_result(exe_result),
      .busy(busy), .retire(retire), .err_code(err_code), .retired_count(retired_count),
      .state_dbg(state_dbg)
   );

   // ---------------- data_mem model ----------------
   logic [DW-1:0] mem [8];
   logic [DW-1:0] rd1_q = '0, rd2_q = '0;
   logic          rd_v = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         mem[0] <= M0; mem[1] <= M1; mem[2] <= '0; mem[3] <= '0;
         mem[4] <= '0; mem[5] <= '0; mem[6] <= '0; mem[7] <= M7;
         rd_v   <= 1'b0;
      end else begin
         rd_v <= mem_read_data;
         if (mem_read_data) begin
            rd1_q <= mem[mem_pointer1];
            rd2_q <= mem[mem_pointer2];
         end
         if (mem_write_data) mem[mem_write_data_pointer] <= mem_data_to_write;
      end
   end
   // Data is only meaningful the cycle after a read; junk otherwise.
   assign mem_data1 = rd_v ? rd1_q : JUNK;
   assign mem_data2 = rd_v ? rd2_q : JUNK;

   // ---------------- engine model (clock only, survives DUT reset) ----------------
   int   eng_lat = 1;   // done in EXEC cycle eng_lat (>=1); 0 = never
   int   eng_cnt = 0;
   logic eng_act = 1'b0;

   function automatic logic [DW-1:0] eng_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a ^ b;
         default: return a;
      endcase
   endfunction

   always @(posedge clk) begin
      exe_done <= 1'b0;
      if (exe_start) begin
         if (eng_lat == 1) begin
            exe_done   <= 1'b1;
            exe_result <= eng_fn(exe_op, exe_opa, exe_opb);
         end else if (eng_lat > 1) begin
            eng_act <= 1'b1;
            eng_cnt <= eng_lat - 1;
         end
      end else if (eng_act) begin
         if (eng_cnt == 1) begin
            exe_done   <= 1'b1;
            exe_result <= eng_fn(exe_op, exe_opa, exe_opb);
            eng_act    <= 1'b0;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   // ---------------- scoreboard / checking ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, ret_cnt = 0, done_cnt = 0;
   int ret_cyc = 0;
   logic [1:0] last_err = '0;
   logic [2:0] last_wr_ptr = '0;

   always @(negedge clk) begin
      if (mem_read_data) rd_cnt++;
      if (mem_read_data && mem_write_data) both_cnt++;
      if (exe_done) done_cnt++;
      if (mem_write_data) begin
         wr_cnt++;
         last_wr_ptr = mem_write_data_pointer;
         if (exp_q.size() == 0) check_eq("wr_unexpected", exp_q.size(), 1);
         else check_eq("wr_data", mem_data_to_write, exp_q.pop_front());
      end
      if (retire) begin
         ret_cnt++;
         last_err = err_code;
         ret_cyc  = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   int acc_cyc = 0;

   task automatic issue(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] dst, input logic wb);
      @(negedge clk);
      instr_op = op; instr_src1 = s1; instr_src2 = s2; instr_dst = dst; instr_wb = wb;
      instr_valid = 1'b1;
      for (int i = 0; i < 300 && !instr_ready; i++) @(negedge clk);
      check_eq("accept", instr_ready, 1'b1);
      acc_cyc = cyc;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic wait_retire(input int target);
      for (int i = 0; i < 300 && ret_cnt < target; i++) @(negedge clk);
      check_eq("retire_wait", ret_cnt >= target, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   int a_acc, snap_wr, snap_ret, snap_rd, snap_done;

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_state", state_dbg, ST_IDLE);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rd_wr_start", {mem_read_data, mem_write_data, exe_start, retire}, 4'b0000);
      check_eq("rst_count", retired_count, 16'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", instr_ready, 1'b1);

      // ADD mem0+mem1 -> mem2, engine done in EXEC cycle 3
      eng_lat = 3;
      exp_q.push_back(R_A);
      issue(4'd1, 3'd0, 3'd1, 3'd2, 1'b1);
      check_eq("t1_state_read", state_dbg, ST_READ);
      check_eq("t1_ready_low", instr_ready, 1'b0);
      check_eq("t1_busy", busy, 1'b1);
      check_eq("t1_ptrs", {mem_pointer1, mem_pointer2}, {3'd0, 3'd1});
      wait_retire(1);
      check_eq("t1_latency", ret_cyc - acc_cyc, 8);
      check_eq("t1_err", last_err, ERR_OK);
      check_eq("t1_count", retired_count, 16'd1);
      check_eq("t1_opa", exe_opa, M0);
      check_eq("t1_opb", exe_opb, M1);
      check_eq("t1_op", exe_op, 4'd1);
      check_eq("t1_wr_cnt", wr_cnt, 1);
      check_eq("t1_wr_ptr", last_wr_ptr, 3'd2);

      // no write-back: retires 4+k after accept, no write pulse
      eng_lat = 2;
      issue(4'd2, 3'd0, 3'd1, 3'd5, 1'b0);
      wait_retire(2);
      check_eq("t2_latency", ret_cyc - acc_cyc, 6);
      check_eq("t2_err", last_err, ERR_OK);
      check_eq("t2_wr_cnt", wr_cnt, 1);
      check_eq("t2_count", retired_count, 16'd2);

      // engine hangs: timeout after 64 EXEC cycles, no write
      eng_lat = 0;
      issue(4'd1, 3'd0, 3'd1, 3'd6, 1'b1);
      wait_retire(3);
      check_eq("t3_latency", ret_cyc - acc_cyc, 67);
      check_eq("t3_err", last_err, ERR_TIMEOUT);
      check_eq("t3_wr_cnt", wr_cnt, 1);
      check_eq("t3_ready_after", instr_ready, 1'b1);

      // back-to-back: A writes mem3, B reads mem3 as operand a
      eng_lat = 1;
      exp_q.push_back(R_A);
      exp_q.push_back(R_B);
      issue(4'd1, 3'd0, 3'd1, 3'd3, 1'b1);
      a_acc = acc_cyc;
      issue(4'd1, 3'd3, 3'd0, 3'd4, 1'b1);
      check_eq("t4a_latency", ret_cyc - a_acc, 6);
      wait_retire(5);
      check_eq("t4b_latency", ret_cyc - acc_cyc, 6);
      check_eq("t4b_opa", exe_opa, R_A);
      check_eq("t4b_opb", exe_opb, M0);
      check_eq("t4_wr_ptr", last_wr_ptr, 3'd4);
      check_eq("t4_count", retired_count, 16'd5);

      // out-of-range operand pointer
      snap_rd = rd_cnt;
      issue(4'd1, 3'd0, 3'd7, 3'd1, 1'b0);
      wait_retire(6);
`ifdef BOUNDS_CHECK_EN
      check_eq("t5_latency", ret_cyc - acc_cyc, 1);
      check_eq("t5_err", last_err, ERR_BAD_PTR);
      check_eq("t5_no_read", rd_cnt, snap_rd);
`else
      check_eq("t5_latency", ret_cyc - acc_cyc, 5);
      check_eq("t5_err", last_err, ERR_OK);
      check_eq("t5_opb", exe_opb, M7);
      check_eq("t5_read", rd_cnt, snap_rd + 1);
`endif
      check_eq("t5_count", retired_count, 16'd6);

      // reset in the middle of EXEC; engine's later done must be ignored
      eng_lat = 5;
      issue(4'd1, 3'd0, 3'd1, 3'd6, 1'b1);
      repeat (3) @(negedge clk);
      check_eq("t6_in_exec", state_dbg, ST_EXEC);
      snap_wr = wr_cnt; snap_ret = ret_cnt; snap_done = done_cnt;
      #1 reset = 1'b0;
      #1;
      check_eq("t6_rst_state", state_dbg, ST_IDLE);
      check_eq("t6_rst_busy", busy, 1'b0);
      check_eq("t6_rst_count", retired_count, 16'd0);
      check_eq("t6_rst_ready", instr_ready, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("t6_late_done_seen", done_cnt, snap_done + 1);
      check_eq("t6_no_write", wr_cnt, snap_wr);
      check_eq("t6_no_retire", ret_cnt, snap_ret);
      check_eq("t6_state_idle", state_dbg, ST_IDLE);

      check_eq("rd_wr_overlap", both_cnt, 0);
      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
